// File: rtl/fc_l2_arb_pkg.sv
// Shared types and helpers for the FC L2 port arbiter slice.
package fc_l2_arb_pkg;

    localparam int unsigned NB_REQ_DFLT = 5;
    localparam int unsigned REQ_IDX_W   = $clog2(NB_REQ_DFLT);

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    localparam req_idx_t CORE_IDX = req_idx_t'(0);

    // Width of an index into n items, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fc_l2_arb_id_fifo.sv
// In-order FIFO of granted requester indices; depth need not be a power of two.
module fc_l2_arb_id_fifo
    import fc_l2_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = REQ_IDX_W
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             push_i,
    input  logic [WIDTH-1:0]                 data_i,
    input  logic                             pop_i,
    output logic [WIDTH-1:0]                 data_o,
    output logic                             full_o,
    output logic                             empty_o,
    output logic [$clog2(DEPTH+1)-1:0]       count_o
);

    localparam int unsigned PTR_W = idx_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fc_l2_port_arbiter.sv
// Round-robin share of one L2 master port among the FC core and HWPE ports,
// with zero added latency and in-order response routing through an ID FIFO.
module fc_l2_port_arbiter
    import fc_l2_arb_pkg::*;
#(
    parameter int unsigned NB_REQ          = 5,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NB_REQ-1:0]              req_i,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]   add_i,
    input  logic [NB_REQ-1:0]              wen_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NB_REQ*DATA_WIDTH/8-1:0] be_i,
    output logic [NB_REQ-1:0]              gnt_o,
    output logic [NB_REQ-1:0]              r_valid_o,
    output logic [DATA_WIDTH-1:0]          r_rdata_o,
    output logic                           r_opc_o,
    output logic                           l2_req_o,
    output logic [ADDR_WIDTH-1:0]          l2_add_o,
    output logic                           l2_wen_o,
    output logic [DATA_WIDTH-1:0]          l2_wdata_o,
    output logic [DATA_WIDTH/8-1:0]        l2_be_o,
    input  logic                           l2_gnt_i,
    input  logic                           l2_r_valid_i,
    input  logic [DATA_WIDTH-1:0]          l2_r_rdata_i,
    input  logic                           l2_r_opc_i,
    output logic                           busy_o,
    output logic                           proto_err_o
);

    localparam int unsigned IDX_W = idx_width(NB_REQ);
    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [ADDR_WIDTH-1:0] add_arr   [NB_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NB_REQ];
    logic [BE_W-1:0]       be_arr    [NB_REQ];

    logic [IDX_W-1:0] rr_ptr_q;
    logic             proto_err_q;
    logic [IDX_W-1:0] win_idx;
    logic             win_found;
    logic [IDX_W-1:0] cand_idx;
    int unsigned      cand;
    logic             handshake;
    logic             pop;
    logic [IDX_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    for (genvar g = 0; g < NB_REQ; g++) begin : g_unpack
        assign add_arr[g]   = add_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
        assign be_arr[g]    = be_i[g*BE_W +: BE_W];
    end

    // First active request scanning circularly from the slot after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 1; k <= NB_REQ; k++) begin
            cand = 32'(rr_ptr_q) + k;
            if (cand >= NB_REQ) cand = cand - NB_REQ;
            cand_idx = IDX_W'(cand);
            if (!win_found && req_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign l2_req_o  = win_found & ~fifo_full;
    assign handshake = l2_req_o & l2_gnt_i;
    assign pop       = l2_r_valid_i & ~fifo_empty;

    always_comb begin
        l2_add_o   = '0;
        l2_wen_o   = 1'b1;
        l2_wdata_o = '0;
        l2_be_o    = '0;
        if (win_found) begin
            l2_add_o   = add_arr[win_idx];
            l2_wen_o   = wen_i[win_idx];
            l2_wdata_o = wdata_arr[win_idx];
            l2_be_o    = be_arr[win_idx];
        end
    end

    always_comb begin
        gnt_o     = '0;
        r_valid_o = '0;
        if (handshake) gnt_o[win_idx]       = 1'b1;
        if (pop)       r_valid_o[fifo_head] = 1'b1;
    end

    assign r_rdata_o   = l2_r_rdata_i;
    assign r_opc_o     = l2_r_opc_i;
    assign busy_o      = (fifo_count != '0);
    assign proto_err_o = proto_err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= IDX_W'(NB_REQ - 1);
            proto_err_q <= 1'b0;
        end else begin
            if (handshake) rr_ptr_q <= win_idx;
            // A response with nothing outstanding is dropped and latched as an error.
            if (l2_r_valid_i && fifo_empty) proto_err_q <= 1'b1;
        end
    end

    fc_l2_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .data_i  (win_idx),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
